// File: rtl/display_top_if.sv
// Board-facing pins of the front panel: push-button inputs plus the two
// multiplexed displays (7-segment digits and ASCII characters).
interface display_top_if;
  logic [3:0] in;
  logic [7:0] char;
  logic [3:0] c_mask;
  logic [6:0] num;
  logic [3:0] n_mask;

  modport master (output in, input char, c_mask, num, n_mask);
  modport slave  (input in, output char, c_mask, num, n_mask);
endinterface

// File: rtl/display_top.sv
// Front-panel controller: debounced-by-sampling buttons drive a 4-digit BCD
// up/down counter shown on a scanned 7-segment display plus a RUN/HOLD banner.
module display_top #(
  parameter int SCAN_DIV = 1000
) (
  input logic          clk,
  input logic          rst,
  display_top_if.slave pins
);
  localparam int            PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    sync1, sync2, smp, press;
  logic [1:0]    idx;
  logic [15:0]   cnt;
  logic          hold;
  logic [3:0]    cur_dig;
  logic [6:0]    num_r;
  logic [7:0]    char_r;
  logic [3:0]    mask_r;

  assign tick  = (presc == PRESC_MAX);
  // Only meaningful at a tick: rising edges between consecutive samples.
  assign press = sync2 & ~smp;

  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (up) begin
          if (v[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
          else begin r[4*k +: 4] = v[4*k +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (v[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'd9;
          else begin r[4*k +: 4] = v[4*k +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  // Position 3 is the leftmost character.
  function automatic logic [7:0] glyph(input logic h, input logic [1:0] i);
    case ({h, i})
      3'b011: return 8'h52;
      3'b010: return 8'h55;
      3'b001: return 8'h4E;
      3'b000: return 8'h20;
      3'b111: return 8'h48;
      3'b110: return 8'h4F;
      3'b101: return 8'h4C;
      default: return 8'h44;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins.in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      smp <= '0;
    end else if (tick) begin
      idx <= idx + 2'd1;
      smp <= sync2;
    end
  end

  // Clear beats hold toggle, and either one suppresses inc/dec at that tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      hold <= 1'b0;
    end else if (tick) begin
      if (press[2]) cnt <= '0;
      else if (press[3]) hold <= ~hold;
      else if (!hold && (press[0] != press[1])) cnt <= bcd_step(cnt, press[0]);
    end
  end

  always_comb begin
    cur_dig = cnt[3:0];
    case (idx)
      2'd1: cur_dig = cnt[7:4];
      2'd2: cur_dig = cnt[11:8];
      2'd3: cur_dig = cnt[15:12];
      default: cur_dig = cnt[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r <= 4'b1110;
      num_r  <= 7'h3F;
      char_r <= 8'h20;
    end else begin
      mask_r <= ~(4'b0001 << idx);
      num_r  <= seg7(cur_dig);
      char_r <= glyph(hold, idx);
    end
  end

  assign pins.n_mask = mask_r;
  assign pins.c_mask = mask_r;
  assign pins.num    = num_r;
  assign pins.char   = char_r;
endmodule

// File: tb/tb_display_top.sv
// Bench for display_top: decimal-integer model of counter, hold and scan,
// compared every cycle, plus hand-computed display expectations.
module tb_display_top;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  display_top_if pins ();
  display_top #(.SCAN_DIV(SD)) dut (.clk(clk), .rst(rst), .pins(pins));

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         m_cnt = 0, m_idx = 0, m_cyc = 0;
  bit         m_hold = 1'b0;
  logic [3:0] m_d1 = '0, m_d2 = '0, m_smp = '0, m_pr;
  logic [3:0] e_mask = 4'b1110;
  logic [6:0] e_num = 7'h3F;
  logic [7:0] e_char = 8'h20;

  function automatic int digit(int v, int i);
    return (v / (10 ** i)) % 10;
  endfunction

  function automatic logic [7:0] glyph(bit h, int i);
    string s;
    s = h ? "HOLD" : "RUN ";
    return s[3-i];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_idx = 0; m_cyc = 0; m_hold = 1'b0;
      m_d1 = '0; m_d2 = '0; m_smp = '0;
      e_mask = 4'b1110; e_num = 7'h3F; e_char = 8'h20;
    end else begin
      e_mask = ~(4'b0001 << m_idx);
      e_num  = seg_tab[digit(m_cnt, m_idx)];
      e_char = glyph(m_hold, m_idx);
      if (m_cyc % SD == SD - 1) begin
        m_pr  = m_d2 & ~m_smp;
        m_smp = m_d2;
        if (m_pr[2]) m_cnt = 0;
        else if (m_pr[3]) m_hold = !m_hold;
        else if (!m_hold && m_pr[0] && !m_pr[1]) m_cnt = (m_cnt + 1) % 10000;
        else if (!m_hold && m_pr[1] && !m_pr[0]) m_cnt = (m_cnt + 9999) % 10000;
        m_idx = (m_idx + 1) % 4;
      end
      m_d2 = m_d1;
      m_d1 = pins.in;
      m_cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("n_mask", 32'(pins.n_mask), 32'(e_mask));
      chk("c_mask", 32'(pins.c_mask), 32'(e_mask));
      chk("num",    32'(pins.num),    32'(e_num));
      chk("char",   32'(pins.char),   32'(e_char));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(logic [3:0] b, int slots);
    @(negedge clk);
    pins.in = b;
    repeat (slots * SD) @(negedge clk);
    pins.in = '0;
    repeat (2 * SD) @(negedge clk);
  endtask

  task automatic find_slot(int i, output bit ok);
    logic [3:0] m;
    m  = ~(4'b0001 << i);
    ok = 1'b0;
    for (int k = 0; k < 8 * SD && !ok; k++) begin
      @(negedge clk);
      if (pins.n_mask == m) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL slot_timeout: index %0d never selected, mask %b", i, pins.n_mask);
    end
  endtask

  task automatic show_num(int i, logic [6:0] en, string nm);
    bit ok;
    find_slot(i, ok);
    if (ok) chk(nm, 32'(pins.num), 32'(en));
  endtask

  task automatic show_char(int i, logic [7:0] ec, string nm);
    bit ok;
    find_slot(i, ok);
    if (ok) chk(nm, 32'(pins.char), 32'(ec));
  endtask

  // Call right after releasing reset at a negedge: one slot is SD clocks.
  task automatic scan_check();
    logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      chk("scan_mask", 32'(pins.n_mask), 32'(seq[s]));
      chk("scan_num",  32'(pins.num), 32'h3F);
      if (s < 4) repeat (SD) @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pins.in = '0;
    #3 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_mask", 32'(pins.n_mask), 32'hE);
    chk("reset_num",  32'(pins.num), 32'h3F);
    chk("reset_char", 32'(pins.char), 32'h20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    scan_check();

    for (int n = 0; n < 12; n++) press(4'b0001, 3);
    chk("model_cnt_12", 32'(m_cnt), 32'd12);
    show_num(0, 7'h5B, "cnt12_d0");
    show_num(1, 7'h06, "cnt12_d1");

    press(4'b0100, 3);
    press(4'b0010, 3);
    chk("model_cnt_9999", 32'(m_cnt), 32'd9999);
    for (int i = 0; i < 4; i++) show_num(i, 7'h6F, "wrap9999");
    press(4'b0001, 3);
    show_num(3, 7'h3F, "wrap0000_d3");
    show_num(0, 7'h3F, "wrap0000_d0");

    press(4'b1000, 3);
    show_char(3, 8'h48, "hold_c3");
    show_char(2, 8'h4F, "hold_c2");
    show_char(1, 8'h4C, "hold_c1");
    show_char(0, 8'h44, "hold_c0");
    press(4'b0001, 3);
    show_num(0, 7'h3F, "held_inc_ignored");
    press(4'b1000, 3);
    show_char(3, 8'h52, "run_c3");
    show_char(2, 8'h55, "run_c2");
    show_char(1, 8'h4E, "run_c1");
    show_char(0, 8'h20, "run_c0");
    press(4'b0001, 3);
    show_num(0, 7'h06, "resume_d0");

    press(4'b0001, 50);
    chk("model_long_hold", 32'(m_cnt), 32'd2);
    show_num(0, 7'h5B, "long_hold_d0");
    press(4'b0011, 3);
    show_num(0, 7'h5B, "inc_dec_nochange");
    press(4'b0101, 3);
    show_num(0, 7'h3F, "clear_inc");

    for (int n = 0; n < 345; n++) press(4'b0001, 1);
    chk("model_cnt_345", 32'(m_cnt), 32'd345);
    show_num(0, 7'h6D, "c345_d0");
    show_num(1, 7'h66, "c345_d1");
    show_num(2, 7'h4F, "c345_d2");
    show_num(3, 7'h3F, "c345_d3");

    show_num(2, 7'h4F, "pre_reset");
    repeat (1) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_mask", 32'(pins.n_mask), 32'hE);
    chk("async_cmask", 32'(pins.c_mask), 32'hE);
    chk("async_num",  32'(pins.num), 32'h3F);
    chk("async_char", 32'(pins.char), 32'h20);
    @(negedge clk);
    rst = 1'b1;
    scan_check();
    for (int i = 0; i < 4; i++) show_num(i, 7'h3F, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/display_top.md
Name: display_top

Overview:
- Front-panel controller: samples four push-buttons and keeps a 4-digit BCD up/down counter (0000–9999).
- Drives a multiplexed 4-digit 7-segment display (`num`/`n_mask`) and a multiplexed 4-character ASCII display (`char`/`c_mask`).
- The character display shows the run state: "RUN " or "HOLD".
- It is the top level of the panel design; all display and button pins connect directly to board I/O.

Parameters:
- `SCAN_DIV`, default 1000: clk cycles per scan slot. It sets both the display digit rate and the button sample rate. Legal values are ≥ 2.

Ports:
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in`, input, 4: push-buttons, active-high, asynchronous to clk. `in[0]`=increment, `in[1]`=decrement, `in[2]`=clear, `in[3]`=hold toggle.
- `char`, output, 8: ASCII code of the character at the currently selected position.
- `c_mask`, output, 4: character position select, one-hot, active-low.
- `num`, output, 7: segment pattern of the selected digit, active-high, bit order {g,f,e,d,c,b,a}.
- `n_mask`, output, 4: digit select, one-hot, active-low.

Behaviour:
- Reset (`rst`=0, asynchronous) forces:
  - prescaler=0, scan index=0, count=0000, hold=0, sampled buttons=0000
  - `n_mask`=`c_mask`=4'b1110, `num`=7'h3F, `char`=8'h20
- Synchronizer: `in` passes through a 2-flop synchronizer, which runs every clock.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` is asserted for one cycle when the prescaler equals SCAN_DIV-1.
- On each `tick`:
  - Scan index advances 0→1→2→3→0.
  - Synchronized buttons are latched into `smp`.
  - A press is a `smp` bit that is 0 at the previous tick and 1 at this tick. A held button acts only once.
- Press handling at a tick, in priority order:
  - clear: count←0000; hold is unchanged.
  - hold: toggle hold.
  - inc and dec together: no change.
  - inc, only when hold=0: count+1 in BCD with decimal carry; 9999 wraps to 0000.
  - dec, only when hold=0: count-1; 0000 wraps to 9999.
  - When clear or hold is pressed, inc and dec at the same tick are ignored.
- Display mapping for scan index i:
  - `n_mask`=`c_mask`=~(1<<i).
  - Digit i is BCD digit i of count; i=0 is the least significant digit and the rightmost.
  - Segment codes 0–9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Non-decimal values cannot occur.
  - Character position i, with i=3 the leftmost:
    - hold=0 → "RUN ": i3=52, i2=55, i1=4E, i0=20
    - hold=1 → "HOLD": i3=48, i2=4F, i1=4C, i0=44
- All outputs are registered:
  - They update the cycle after a tick, and after any count/hold change.
  - Outputs always reflect the current index, count and hold with 1-cycle latency.
- Masks are always exactly one-hot-low, never 1111, including during and after reset.
- Reset mid-scan aborts immediately. Scanning restarts at index 0 one full SCAN_DIV period after release.

Test Plan (SCAN_DIV=4 unless noted):
- Reset, then release → outputs 1110/1110/3F/20. Mask sequence 1110,1101,1011,0111,1110 with 4 clk per slot; `num` shows 3F at every index.
- Pulse `in[0]` for 3 slots, 12 times → count 0012. At index 0 `num`=5B (2); at index 1 `num`=06 (1).
- From 9999, one inc press → 0000. From 0000, one dec press → 9999; every digit shows 6F.
- Press `in[3]` → chars at index 3..0 are 48,4F,4C,44. Inc presses are ignored. Press `in[3]` again → 52,55,4E,20 and counting resumes.
- Hold `in[0]` high for 50 slots → count increments exactly once. Inc+dec pressed together → no change. Clear+inc together → 0000.
- Assert `rst` low mid-slot with count=0345 → immediate 1110/3F/20 and count 0000, without waiting for a clk edge.
